// File: rtl/serial_pkg.sv
// Shared definitions for the serial word assembler.
//   out_state_t   : state of the one-word output holding register
//   DEFAULT_WIDTH : default number of bits per assembled word
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Shift register plus bit counter for the serial word assembler.
// Ports:
//   clk, rest  : clock, asynchronous active-low reset
//   bit_in     : serial data bit, sampled when bit_valid is high
//   bit_valid  : qualifies bit_in on this edge
//   clr        : synchronous clear of shift register and counter
//   word       : complete word including the current bit (valid with done)
//   done       : high during the cycle whose edge accepts the WIDTH-th bit
//   bit_count  : bits collected in the current partial word
module serial_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     clr,
  output logic [WIDTH-1:0]         word,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    count_q;
  logic             last_bit;

  // MSB_FIRST shifts toward the MSB so the first bit ends in word[WIDTH-1];
  // otherwise shift toward the LSB so the first bit ends in word[0].
  always_comb begin
    sr_next = sr_q;
    if (MSB_FIRST) begin
      sr_next = {sr_q[WIDTH-2:0], bit_in};
    end else begin
      sr_next = {bit_in, sr_q[WIDTH-1:1]};
    end
  end

  assign last_bit  = (count_q == CW'(WIDTH - 1));
  // Completion is suppressed by clr: a bit on a clearing edge is ignored.
  assign done      = bit_valid && last_bit && !clr;
  assign word      = sr_next;
  assign bit_count = count_q;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      sr_q    <= '0;
      count_q <= '0;
    end else if (clr) begin
      sr_q    <= '0;
      count_q <= '0;
    end else if (bit_valid) begin
      sr_q    <= sr_next;
      count_q <= last_bit ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_assembler.sv
// Collects a registered serial bit stream into WIDTH-bit words and presents
// them through a one-word holding register.
// Ports:
//   clk, rest   : clock, asynchronous active-low reset
//   bit_in      : serial data bit
//   bit_valid   : bit_in is sampled on this edge when high
//   clr         : synchronous clear of assembly state, output state, overflow
//   data_out    : assembled word held in the output register
//   data_valid  : data_out holds an unconsumed word
//   data_ready  : downstream accepts data_out
//   bit_count   : bits collected in the current partial word
//   overflow    : sticky, a completed word was dropped
//   fsm_state   : current output FSM state (debug)
//
// Handshake: a word transfers on a rising edge where data_valid and
// data_ready are both high; data_out is stable while data_valid is high and
// data_ready is low. A word completing while the register is full and not
// being drained is discarded and sets overflow.
module serial_word_assembler
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     clr,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overflow,
  output out_state_t               fsm_state
);

  logic [WIDTH-1:0] word;
  logic             done;

  out_state_t       state_q;
  out_state_t       state_next;
  logic             load_word;
  logic             set_overflow;
  logic [WIDTH-1:0] data_q;
  logic             overflow_q;

  serial_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rest      (rest),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr       (clr),
    .word      (word),
    .done      (done),
    .bit_count (bit_count)
  );

  always_comb begin
    state_next   = state_q;
    load_word    = 1'b0;
    set_overflow = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (done) begin
          state_next = OUT_FULL;
          load_word  = 1'b1;
        end
      end
      OUT_FULL: begin
        if (data_ready) begin
          // Draining and refilling on the same edge keeps the FSM full.
          if (done) begin
            load_word = 1'b1;
          end else begin
            state_next = OUT_EMPTY;
          end
        end else if (done) begin
          set_overflow = 1'b1;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q    <= OUT_EMPTY;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else if (clr) begin
      // data_q is deliberately kept: only validity is cleared.
      state_q    <= OUT_EMPTY;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_next;
      if (load_word) begin
        data_q <= word;
      end
      if (set_overflow) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = (state_q == OUT_FULL);
  assign overflow   = overflow_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
module tb_serial_word_assembler;
  import serial_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rest;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic bit_in;
  logic bit_valid;
  logic clr;
  logic data_ready;

  // MSB-first instance
  logic [W-1:0]  dout_m;
  logic          dv_m;
  logic [CW-1:0] cnt_m;
  logic          ovf_m;
  out_state_t    st_m;

  // LSB-first instance
  logic [W-1:0]  dout_l;
  logic          dv_l;
  logic [CW-1:0] cnt_l;
  logic          ovf_l;
  out_state_t    st_l;

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rest(rest), .bit_in(bit_in), .bit_valid(bit_valid), .clr(clr),
    .data_out(dout_m), .data_valid(dv_m), .data_ready(data_ready),
    .bit_count(cnt_m), .overflow(ovf_m), .fsm_state(st_m)
  );

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rest(rest), .bit_in(bit_in), .bit_valid(bit_valid), .clr(clr),
    .data_out(dout_l), .data_valid(dv_l), .data_ready(data_ready),
    .bit_count(cnt_l), .overflow(ovf_l), .fsm_state(st_l)
  );

  // ---------------- reference model ----------------
  // Received bits of the current partial word, in arrival order.
  logic          bits_q[$];
  logic          m_full;
  logic          m_ovf;
  logic [W-1:0]  m_held_m;
  logic [W-1:0]  m_held_l;
  logic [W-1:0]  exp_m[$];
  logic [W-1:0]  exp_l[$];

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    m_full   = 1'b0;
    m_ovf    = 1'b0;
    m_held_m = '0;
    m_held_l = '0;
    exp_m.delete();
    exp_l.delete();
  endtask

  // Effect of one rising edge with the given inputs.
  task automatic model_edge(input logic bv, input logic bi, input logic rdy, input logic c);
    logic         done;
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (c) begin
      bits_q.delete();
      if (m_full) begin
        void'(exp_m.pop_back());
        void'(exp_l.pop_back());
      end
      m_full = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (bv) begin
        bits_q.push_back(bi);
        if (bits_q.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bits_q[i];
            wl[i]     = bits_q[i];
          end
          bits_q.delete();
        end
      end
      if (done) begin
        if (!m_full || rdy) begin
          m_full   = 1'b1;
          m_held_m = wm;
          m_held_l = wl;
          exp_m.push_back(wm);
          exp_l.push_back(wl);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_full && rdy) begin
        m_full = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic bv, input logic bi, input logic rdy, input logic c);
    bit_valid  = bv;
    bit_in     = bv ? bi : 1'($urandom);
    data_ready = rdy;
    clr        = c;
    @(posedge clk);
    #1;
    if (rest) model_edge(bv, bit_in, rdy, c);
  endtask

  // Sends w[7] first; optional idle gaps with bit_in toggling.
  task automatic send_bits(input logic [7:0] w, input int gap_max, input logic rdy,
                           input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) step(1'b0, 1'b0, rdy, 1'b0);
      step(1'b1, w[7-i], (i == 7) ? rdy_last : rdy, 1'b0);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rest) begin
      chk("valid_m", 32'(dv_m), 32'(m_full));
      chk("valid_l", 32'(dv_l), 32'(m_full));
      chk("ovf_m", 32'(ovf_m), 32'(m_ovf));
      chk("ovf_l", 32'(ovf_l), 32'(m_ovf));
      chk("count_m", 32'(cnt_m), 32'(bits_q.size()));
      chk("count_l", 32'(cnt_l), 32'(bits_q.size()));
      chk("hold_m", 32'(dout_m), 32'(m_held_m));
      chk("hold_l", 32'(dout_l), 32'(m_held_l));
      if (dv_m && data_ready && !clr) begin
        if (exp_m.size() == 0) begin
          chk("xfer_m_underflow", 32'(exp_m.size()), 32'd1);
        end else begin
          chk("xfer_m", 32'(dout_m), 32'(exp_m.pop_front()));
        end
      end
      if (dv_l && data_ready && !clr) begin
        if (exp_l.size() == 0) begin
          chk("xfer_l_underflow", 32'(exp_l.size()), 32'd1);
        end else begin
          chk("xfer_l", 32'(dout_l), 32'(exp_l.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    clr        = 1'b0;
    data_ready = 1'b0;
    rest       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(dv_m), 32'd0);
    chk("rst_data", 32'(dout_m), 32'd0);
    chk("rst_count", 32'(cnt_m), 32'd0);
    chk("rst_ovf", 32'(ovf_m), 32'd0);
    rest = 1'b1;

    // 1: reset mid-word, then A5
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    rest = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_rst_count", 32'(cnt_m), 32'd0);
    chk("t1_rst_data", 32'(dout_m), 32'd0);
    rest = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'hA5, 0, 1'b0, 1'b0);
    chk("t1_data", 32'(dout_m), 32'hA5);
    chk("t1_valid", 32'(dv_m), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 2: back-to-back with ready high, one-cycle valid
    send_bits(8'hA5, 0, 1'b1, 1'b1);
    chk("t2_valid", 32'(dv_m), 32'd1);
    chk("t2_data", 32'(dout_m), 32'hA5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_valid_drop", 32'(dv_m), 32'd0);
    chk("t2_ovf", 32'(ovf_m), 32'd0);

    // 3: overflow while stalled, sticky after drain, cleared by clr
    send_bits(8'h3C, 0, 1'b0, 1'b0);
    send_bits(8'hFF, 0, 1'b0, 1'b0);
    chk("t3_data", 32'(dout_m), 32'h3C);
    chk("t3_ovf", 32'(ovf_m), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_valid_drain", 32'(dv_m), 32'd0);
    chk("t3_ovf_sticky", 32'(ovf_m), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(ovf_m), 32'd0);

    // 4: drain and refill on the same edge
    send_bits(8'h3C, 0, 1'b0, 1'b0);
    send_bits(8'h81, 0, 1'b0, 1'b1);
    chk("t4_valid", 32'(dv_m), 32'd1);
    chk("t4_data", 32'(dout_m), 32'h81);
    chk("t4_ovf", 32'(ovf_m), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 5: idle gaps between bits
    send_bits(8'h5A, 3, 1'b0, 1'b0);
    chk("t5_data", 32'(dout_m), 32'h5A);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 6: LSB-first word, then clr on the completing bit
    send_bits(8'h80, 0, 1'b0, 1'b0);
    chk("t6_data_l", 32'(dout_l), 32'h01);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_clr_count", 32'(cnt_l), 32'd0);
    chk("t6_clr_valid", 32'(dv_l), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic c;
      c = ($urandom_range(0, 63) == 0);
      step($urandom_range(0, 3) != 0, 1'($urandom), c ? 1'b0 : 1'($urandom), c);
    end

    // drain
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_m", 32'(exp_m.size()), 32'd0);
    chk("drain_l", 32'(exp_l.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
